// File: rtl/block_pkg.sv
// Shared types and constants for the block-structured text stream generator.
// Holds the FSM state encoding, the ASCII letters of "begin"/"end" and the case offset.
package block_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_SEP  = 2'd2
    } state_e;

    localparam logic [7:0] CH_B        = 8'h62;
    localparam logic [7:0] CH_E        = 8'h65;
    localparam logic [7:0] CH_G        = 8'h67;
    localparam logic [7:0] CH_I        = 8'h69;
    localparam logic [7:0] CH_N        = 8'h6E;
    localparam logic [7:0] CH_D        = 8'h64;
    localparam logic [7:0] CH_SPACE    = 8'h20;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    // Letter count of the word selected by the close bit.
    function automatic logic [2:0] word_len(input logic close);
        logic [2:0] len;
        if (close) begin
            len = 3'd3;
        end else begin
            len = 3'd5;
        end
        return len;
    endfunction

endpackage

// File: rtl/block_word_rom.sv
// Combinational letter lookup: (close, idx, upper) -> ASCII byte plus last-letter flag.
module block_word_rom
    import block_pkg::*;
(
    input  logic       close,
    input  logic [2:0] idx,
    input  logic       upper,
    output logic [7:0] ch,
    output logic       last
);

    logic [7:0] lower_s;

    // Select the lower-case letter of "end" or "begin".
    always_comb begin
        lower_s = CH_SPACE;
        if (close) begin
            case (idx)
                3'd0:    lower_s = CH_E;
                3'd1:    lower_s = CH_N;
                3'd2:    lower_s = CH_D;
                default: lower_s = CH_SPACE;
            endcase
        end else begin
            case (idx)
                3'd0:    lower_s = CH_B;
                3'd1:    lower_s = CH_E;
                3'd2:    lower_s = CH_G;
                3'd3:    lower_s = CH_I;
                3'd4:    lower_s = CH_N;
                default: lower_s = CH_SPACE;
            endcase
        end
    end

    // Apply letter case and flag the final letter of the word.
    always_comb begin
        if (upper) begin
            ch = lower_s - CASE_OFFSET;
        end else begin
            ch = lower_s;
        end
        last = (idx == (word_len(close) - 3'd1));
    end

endmodule

// File: rtl/block_stream_gen.sv
// Serialises open/close commands into "begin "/"end " byte streams and tracks
// nesting depth with sticky underflow/overflow flags feeding the balanced output.
module block_stream_gen
    import block_pkg::*;
#(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_close,
    input  logic               cmd_upper,
    output logic [7:0]         out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DEPTH_W-1:0] depth,
    output logic               balanced,
    output logic               ovf
);

    localparam logic [DEPTH_W-1:0] DEPTH_ZERO = {DEPTH_W{1'b0}};
    localparam logic [DEPTH_W-1:0] DEPTH_MAX  = {DEPTH_W{1'b1}};
    localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1'b1);

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic               close_q, close_d;
    logic               upper_q, upper_d;
    logic               last_q, last_d;
    logic [7:0]         out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               unbal_q, unbal_d;
    logic               ovf_q, ovf_d;
    logic               balanced_q, balanced_d;

    logic               rom_close_s;
    logic [2:0]         rom_idx_s;
    logic               rom_upper_s;
    logic [7:0]         rom_ch_s;
    logic               rom_last_s;
    logic               xfer_s;

    assign cmd_ready = (state_q == ST_IDLE);
    assign xfer_s    = out_valid_q && out_ready;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign depth     = depth_q;
    assign balanced  = balanced_q;
    assign ovf       = ovf_q;

    // The ROM looks ahead: the first letter of an incoming command, or the next letter.
    always_comb begin
        if (state_q == ST_IDLE) begin
            rom_close_s = cmd_close;
            rom_idx_s   = 3'd0;
            rom_upper_s = cmd_upper;
        end else begin
            rom_close_s = close_q;
            rom_idx_s   = idx_q + 3'd1;
            rom_upper_s = upper_q;
        end
    end

    block_word_rom u_rom (
        .close (rom_close_s),
        .idx   (rom_idx_s),
        .upper (rom_upper_s),
        .ch    (rom_ch_s),
        .last  (rom_last_s)
    );

    // Next-state, next-byte and depth/flag computation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        close_d     = close_q;
        upper_d     = upper_q;
        last_d      = last_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        depth_d     = depth_q;
        unbal_d     = unbal_q;
        ovf_d       = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d     = ST_EMIT;
                    idx_d       = 3'd0;
                    close_d     = cmd_close;
                    upper_d     = cmd_upper;
                    out_d       = rom_ch_s;
                    last_d      = rom_last_s;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            ST_EMIT: begin
                if (xfer_s && last_q) begin
                    state_d = ST_SEP;
                    out_d   = CH_SPACE;
                end else if (xfer_s) begin
                    idx_d  = idx_q + 3'd1;
                    out_d  = rom_ch_s;
                    last_d = rom_last_s;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_SEP: begin
                // The word resolves here, matching where the checker consumes the space.
                if (xfer_s) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_d       = 8'h00;
                    if (!close_q) begin
                        if (depth_q == DEPTH_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            depth_d = depth_q + DEPTH_ONE;
                        end
                    end else begin
                        if (depth_q == DEPTH_ZERO) begin
                            unbal_d = 1'b1;
                        end else begin
                            depth_d = depth_q - DEPTH_ONE;
                        end
                    end
                end else begin
                    state_d = ST_SEP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        balanced_d = (depth_d == DEPTH_ZERO) && !unbal_d && !ovf_d;
    end

    // State, output and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            close_q     <= 1'b0;
            upper_q     <= 1'b0;
            last_q      <= 1'b0;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
            depth_q     <= DEPTH_ZERO;
            unbal_q     <= 1'b0;
            ovf_q       <= 1'b0;
            balanced_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            close_q     <= close_d;
            upper_q     <= upper_d;
            last_q      <= last_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            depth_q     <= depth_d;
            unbal_q     <= unbal_d;
            ovf_q       <= ovf_d;
            balanced_q  <= balanced_d;
        end
    end

endmodule
